// File: rtl/change_dispenser.sv
// change_dispenser: pays out (balance - PRICE) as change, one coin at a time,
// greedy over 20/10/5 denominations, via a valid/ack handshake to the
// coin-return mechanism. Reports completion, underpayment and unpayable residue.
//
// Optional build macro: CHANGE_INVENTORY_EN
//   Adds per-denomination stock counters (INV_20/INV_10/INV_5 at reset),
//   skips empty denominations and adds the stock_empty output.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   sale_valid   one-cycle sale pulse from the vending FSM
//   balance      accumulated balance, sampled when a sale is accepted
//   sale_ready   high in IDLE only (combinational, state decode)
//   coin_out     denomination on offer (5/10/20), 0 when coin_valid=0
//   coin_valid   coin_out valid, held until coin_ack
//   coin_ack     coin-return mechanism took the coin this cycle
//   busy         high in every state except IDLE (combinational, state decode)
//   done         one-cycle pulse at the end of every accepted sale
//   underpay     sticky per sale: balance < PRICE
//   short        sticky per sale: nonzero residue could not be paid
//   coins_paid   coins dispensed for the current/last sale (saturates at 15)
//   stock_empty  all three stock counters are zero (CHANGE_INVENTORY_EN only)
module change_dispenser #(
  parameter int unsigned PRICE  = 40,
  parameter int unsigned BAL_W  = 6,
  parameter int unsigned COIN_W = 5
`ifdef CHANGE_INVENTORY_EN
  ,
  parameter int unsigned INV_20 = 4,
  parameter int unsigned INV_10 = 4,
  parameter int unsigned INV_5  = 8
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sale_valid,
  input  logic [BAL_W-1:0]  balance,
  output logic              sale_ready,
  output logic [COIN_W-1:0] coin_out,
  output logic              coin_valid,
  input  logic              coin_ack,
  output logic              busy,
  output logic              done,
  output logic              underpay,
  output logic              short,
  output logic [3:0]        coins_paid
`ifdef CHANGE_INVENTORY_EN
  ,
  output logic              stock_empty
`endif
);

  localparam int unsigned CP_W  = 4;
  localparam int unsigned CNT_W = 4;

  localparam logic [BAL_W-1:0]  PRICE_B = BAL_W'(PRICE);
  localparam logic [BAL_W-1:0]  R20     = BAL_W'(20);
  localparam logic [BAL_W-1:0]  R10     = BAL_W'(10);
  localparam logic [BAL_W-1:0]  R5      = BAL_W'(5);
  localparam logic [COIN_W-1:0] D20     = COIN_W'(20);
  localparam logic [COIN_W-1:0] D10     = COIN_W'(10);
  localparam logic [COIN_W-1:0] D5      = COIN_W'(5);
  localparam logic [CP_W-1:0]   CP_MAX  = '1;

  typedef enum logic [1:0] {IDLE, SELECT, EMIT, FIN} state_t;

  state_t            state, state_d;
  logic [BAL_W-1:0]  rem, rem_d;
  logic [COIN_W-1:0] coin_out_d;
  logic              coin_valid_d;
  logic              done_d;
  logic              underpay_d;
  logic              short_d;
  logic [CP_W-1:0]   coins_paid_d;

  // Denomination availability: stock-limited or unlimited
  logic has20, has10, has5;
  logic take20, take10, take5;

`ifdef CHANGE_INVENTORY_EN
  logic [CNT_W-1:0] cnt20, cnt20_d;
  logic [CNT_W-1:0] cnt10, cnt10_d;
  logic [CNT_W-1:0] cnt5, cnt5_d;
  logic             stock_empty_d;

  assign has20 = (cnt20 != '0);
  assign has10 = (cnt10 != '0);
  assign has5  = (cnt5 != '0);
`else
  assign has20 = 1'b1;
  assign has10 = 1'b1;
  assign has5  = 1'b1;
`endif

  // Greedy pick, falling through to the next smaller usable denomination
  assign take20 = (rem >= R20) && has20;
  assign take10 = (rem >= R10) && has10;
  assign take5  = (rem >= R5) && has5;

  assign busy       = (state != IDLE);
  assign sale_ready = (state == IDLE);

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state;
    rem_d        = rem;
    coin_out_d   = coin_out;
    coin_valid_d = coin_valid;
    done_d       = 1'b0;
    underpay_d   = underpay;
    short_d      = short;
    coins_paid_d = coins_paid;
`ifdef CHANGE_INVENTORY_EN
    cnt20_d      = cnt20;
    cnt10_d      = cnt10;
    cnt5_d       = cnt5;
`endif

    case (state)
      IDLE: begin
        if (sale_valid) begin
          underpay_d   = 1'b0;
          short_d      = 1'b0;
          coins_paid_d = '0;
          if (balance >= PRICE_B) begin
            rem_d = balance - PRICE_B;
          end else begin
            rem_d      = '0;
            underpay_d = 1'b1;
          end
          state_d = SELECT;
        end
      end

      SELECT: begin
        if (take20) begin
          coin_out_d   = D20;
          coin_valid_d = 1'b1;
          state_d      = EMIT;
        end else if (take10) begin
          coin_out_d   = D10;
          coin_valid_d = 1'b1;
          state_d      = EMIT;
        end else if (take5) begin
          coin_out_d   = D5;
          coin_valid_d = 1'b1;
          state_d      = EMIT;
        end else begin
          // Residue below 5, or no usable stock left for it
          if (rem != '0) begin
            short_d = 1'b1;
          end
          done_d  = 1'b1;
          state_d = FIN;
        end
      end

      EMIT: begin
        if (coin_ack) begin
          rem_d        = rem - BAL_W'(coin_out);
          coins_paid_d = (coins_paid == CP_MAX) ? coins_paid : coins_paid + CP_W'(1);
          coin_valid_d = 1'b0;
          coin_out_d   = '0;
`ifdef CHANGE_INVENTORY_EN
          if (coin_out == D20) begin
            cnt20_d = cnt20 - CNT_W'(1);
          end else if (coin_out == D10) begin
            cnt10_d = cnt10 - CNT_W'(1);
          end else begin
            cnt5_d = cnt5 - CNT_W'(1);
          end
`endif
          state_d = SELECT;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef CHANGE_INVENTORY_EN
    stock_empty_d = (cnt20_d == '0) && (cnt10_d == '0) && (cnt5_d == '0);
`endif
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rem        <= '0;
      coin_out   <= '0;
      coin_valid <= 1'b0;
      done       <= 1'b0;
      underpay   <= 1'b0;
      short      <= 1'b0;
      coins_paid <= '0;
`ifdef CHANGE_INVENTORY_EN
      cnt20       <= CNT_W'(INV_20);
      cnt10       <= CNT_W'(INV_10);
      cnt5        <= CNT_W'(INV_5);
      stock_empty <= (INV_20 == 0) && (INV_10 == 0) && (INV_5 == 0);
`endif
    end else begin
      state      <= state_d;
      rem        <= rem_d;
      coin_out   <= coin_out_d;
      coin_valid <= coin_valid_d;
      done       <= done_d;
      underpay   <= underpay_d;
      short      <= short_d;
      coins_paid <= coins_paid_d;
`ifdef CHANGE_INVENTORY_EN
      cnt20       <= cnt20_d;
      cnt10       <= cnt10_d;
      cnt5        <= cnt5_d;
      stock_empty <= stock_empty_d;
`endif
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser. Expected coin sequences come from
// a greedy change model pushed to a queue when a sale is driven; coins seen on
// the handshake are collected and popped against it.
`timescale 1ns/1ps
module tb_change_dispenser;

  localparam int PRICE  = 40;
  localparam int BAL_W  = 6;
  localparam int COIN_W = 5;
`ifdef CHANGE_INVENTORY_EN
  localparam int T_INV_20 = 0;
  localparam int T_INV_10 = 4;
  localparam int T_INV_5  = 8;
`endif

  logic              clk;
  logic              rst;
  logic              sale_valid;
  logic [BAL_W-1:0]  balance;
  logic              sale_ready;
  logic [COIN_W-1:0] coin_out;
  logic              coin_valid;
  logic              coin_ack;
  logic              busy;
  logic              done;
  logic              underpay;
  logic              short;
  logic [3:0]        coins_paid;
`ifdef CHANGE_INVENTORY_EN
  logic              stock_empty;
`endif

  int n_cmp;
  int n_bad;
  int exp_q[$];
  int obs_q[$];
  int m20, m10, m5;
  bit exp_up, exp_sh;
  int exp_cp;

  change_dispenser #(
    .PRICE(PRICE), .BAL_W(BAL_W), .COIN_W(COIN_W)
`ifdef CHANGE_INVENTORY_EN
    , .INV_20(T_INV_20), .INV_10(T_INV_10), .INV_5(T_INV_5)
`endif
  ) dut (
    .clk(clk), .rst(rst), .sale_valid(sale_valid), .balance(balance),
    .sale_ready(sale_ready), .coin_out(coin_out), .coin_valid(coin_valid),
    .coin_ack(coin_ack), .busy(busy), .done(done), .underpay(underpay),
    .short(short), .coins_paid(coins_paid)
`ifdef CHANGE_INVENTORY_EN
    , .stock_empty(stock_empty)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
`ifdef CHANGE_INVENTORY_EN
    m20 = T_INV_20; m10 = T_INV_10; m5 = T_INV_5;
`else
    m20 = 1000; m10 = 1000; m5 = 1000;
`endif
  endtask

  // Greedy change model: pushes expected coins, sets expected flags
  task automatic predict(input int bal);
    int rem;
    int c;
    exp_up = (bal < PRICE);
    rem    = exp_up ? 0 : bal - PRICE;
    exp_sh = 1'b0;
    exp_cp = 0;
    while (rem > 0) begin
      c = 0;
      if (rem >= 20 && m20 > 0) c = 20;
      else if (rem >= 10 && m10 > 0) c = 10;
      else if (rem >= 5 && m5 > 0) c = 5;
      if (c == 0) begin
        exp_sh = 1'b1;
        break;
      end
      rem -= c;
      exp_q.push_back(c);
      if (exp_cp < 15) exp_cp++;
      if (c == 20) m20--;
      else if (c == 10) m10--;
      else m5--;
    end
  endtask

  // Drives one sale and serves coins; ack_delay < 0 keeps coin_ack tied high.
  // Collects accepted coins into obs_q; returns at the negedge where done=1.
  task automatic run_sale(input int bal, input int ack_delay, input bit poke,
                          output bit timeout, output int done_k, output int first_k,
                          output int hold, output bit unstable);
    int wait_c;
    int ncoin;
    logic [COIN_W-1:0] held;
    timeout = 1'b1; done_k = -1; first_k = -1; hold = 0; unstable = 1'b0;
    wait_c = 0; ncoin = 0; held = '0;
    @(negedge clk);
    sale_valid = 1'b1;
    balance    = BAL_W'(bal);
    coin_ack   = (ack_delay < 0);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      sale_valid = 1'b0;
      if (done) begin
        done_k  = k;
        timeout = 1'b0;
        break;
      end
      if (coin_valid) begin
        if (first_k < 0) first_k = k;
        if (ncoin == 0) hold++;
        if (wait_c == 0) held = coin_out;
        else if (coin_out !== held) unstable = 1'b1;
        if (poke) begin
          sale_valid = 1'b1;
          balance    = BAL_W'(63);
        end
        if (ack_delay < 0 || wait_c == ack_delay) begin
          coin_ack = 1'b1;
          obs_q.push_back(int'(coin_out));
          ncoin++;
          wait_c = 0;
        end else begin
          coin_ack = 1'b0;
          wait_c++;
        end
      end else begin
        coin_ack = (ack_delay < 0);
        wait_c   = 0;
      end
    end
    coin_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; sale_valid = 1'b0; coin_ack = 1'b0; balance = '0;
    #3;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (sale_ready !== 1'b1) begin n_bad++; $display("FAIL rst_sale_ready got %b want 1", sale_ready); end
    n_cmp++; if (coin_valid !== 1'b0) begin n_bad++; $display("FAIL rst_coin_valid got %b want 0", coin_valid); end
    n_cmp++; if (coin_out !== 5'd0) begin n_bad++; $display("FAIL rst_coin_out got %0d want 0", coin_out); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", done); end
    n_cmp++; if ({underpay, short} !== 2'b00) begin n_bad++; $display("FAIL rst_flags got %b want 00", {underpay, short}); end
    n_cmp++; if (coins_paid !== 4'd0) begin n_bad++; $display("FAIL rst_coins_paid got %0d want 0", coins_paid); end
`ifdef CHANGE_INVENTORY_EN
    n_cmp++; if (stock_empty !== 1'b0) begin n_bad++; $display("FAIL rst_stock_empty got %b want 0", stock_empty); end
`endif
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_exact();
    bit to, us; int dk, fk, hd; int e;
    predict(45);
    run_sale(45, -1, 1'b0, to, dk, fk, hd, us);
    n_cmp++; if (to) begin n_bad++; $display("FAIL exact_timeout got no done want done"); end
    n_cmp++; if (dk !== 4) begin n_bad++; $display("FAIL exact_done_cycle got %0d want 4", dk); end
    n_cmp++; if (fk !== 2) begin n_bad++; $display("FAIL exact_first_coin_cycle got %0d want 2", fk); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL exact_coin got none want %0d", e); end
      else if (obs_q[0] !== e) begin n_bad++; $display("FAIL exact_coin got %0d want %0d", obs_q.pop_front(), e); end
      else void'(obs_q.pop_front());
    end
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL exact_extra_coins got %0d want 0", obs_q.size()); obs_q.delete(); end
    n_cmp++; if ({underpay, short} !== {exp_up, exp_sh}) begin n_bad++; $display("FAIL exact_flags got %b want %b", {underpay, short}, {exp_up, exp_sh}); end
    n_cmp++; if (coins_paid !== 4'(exp_cp)) begin n_bad++; $display("FAIL exact_coins_paid got %0d want %0d", coins_paid, exp_cp); end
    @(negedge clk);
    n_cmp++; if ({done, sale_ready} !== 2'b01) begin n_bad++; $display("FAIL exact_done_pulse got %b want 01", {done, sale_ready}); end
  endtask

  task automatic test_short();
    bit to, us; int dk, fk, hd; int e;
    predict(63);
    run_sale(63, 0, 1'b0, to, dk, fk, hd, us);
    n_cmp++; if (to) begin n_bad++; $display("FAIL short_timeout got no done want done"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL short_coin got none want %0d", e); end
      else if (obs_q[0] !== e) begin n_bad++; $display("FAIL short_coin got %0d want %0d", obs_q.pop_front(), e); end
      else void'(obs_q.pop_front());
    end
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL short_extra_coins got %0d want 0", obs_q.size()); obs_q.delete(); end
    n_cmp++; if ({underpay, short} !== {exp_up, exp_sh}) begin n_bad++; $display("FAIL short_flags got %b want %b", {underpay, short}, {exp_up, exp_sh}); end
    n_cmp++; if (coins_paid !== 4'(exp_cp)) begin n_bad++; $display("FAIL short_coins_paid got %0d want %0d", coins_paid, exp_cp); end
    @(negedge clk);
  endtask

  task automatic test_underpay();
    bit to, us; int dk, fk, hd;
    predict(35);
    run_sale(35, 0, 1'b0, to, dk, fk, hd, us);
    n_cmp++; if (dk !== 2) begin n_bad++; $display("FAIL underpay_done_cycle got %0d want 2", dk); end
    n_cmp++; if (fk !== -1) begin n_bad++; $display("FAIL underpay_coin_valid got cycle %0d want none", fk); end
    n_cmp++; if ({underpay, short} !== {exp_up, exp_sh}) begin n_bad++; $display("FAIL underpay_flags got %b want %b", {underpay, short}, {exp_up, exp_sh}); end
    n_cmp++; if (coins_paid !== 4'd0) begin n_bad++; $display("FAIL underpay_coins_paid got %0d want 0", coins_paid); end
    obs_q.delete();
    @(negedge clk);
    n_cmp++; if ({sale_ready, busy, done} !== 3'b100) begin n_bad++; $display("FAIL underpay_idle got %b want 100", {sale_ready, busy, done}); end
  endtask

  task automatic test_slow_ack();
    bit to, us; int dk, fk, hd; int e;
    predict(60);
    run_sale(60, 3, 1'b1, to, dk, fk, hd, us);
    n_cmp++; if (to) begin n_bad++; $display("FAIL slow_timeout got no done want done"); end
    n_cmp++; if (hd !== 4) begin n_bad++; $display("FAIL slow_hold_cycles got %0d want 4", hd); end
    n_cmp++; if (us !== 1'b0) begin n_bad++; $display("FAIL slow_coin_stable got unstable want stable"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL slow_coin got none want %0d", e); end
      else if (obs_q[0] !== e) begin n_bad++; $display("FAIL slow_coin got %0d want %0d", obs_q.pop_front(), e); end
      else void'(obs_q.pop_front());
    end
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL slow_extra_coins got %0d want 0", obs_q.size()); obs_q.delete(); end
    // Pokes during EMIT must not have started a second sale
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if ({busy, coins_paid} !== {1'b0, 4'(exp_cp)}) begin n_bad++; $display("FAIL slow_ignored_sale got busy=%b paid=%0d want busy=0 paid=%0d", busy, coins_paid, exp_cp); end
  endtask

  task automatic test_reset_mid();
    bit to, us, seen; int dk, fk, hd; int e;
    seen = 1'b0;
    @(negedge clk);
    sale_valid = 1'b1; balance = BAL_W'(60); coin_ack = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      sale_valid = 1'b0;
      if (coin_valid) begin seen = 1'b1; break; end
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL rstmid_emit got no coin_valid want coin_valid"); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if ({coin_valid, busy, sale_ready, coins_paid} !== {3'b001, 4'd0}) begin
      n_bad++; $display("FAIL rstmid_abort got valid=%b busy=%b ready=%b paid=%0d want 0 0 1 0", coin_valid, busy, sale_ready, coins_paid);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    obs_q.delete();
    predict(50);
    run_sale(50, 1, 1'b0, to, dk, fk, hd, us);
    n_cmp++; if (to) begin n_bad++; $display("FAIL rstmid_timeout got no done want done"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL rstmid_coin got none want %0d", e); end
      else if (obs_q[0] !== e) begin n_bad++; $display("FAIL rstmid_coin got %0d want %0d", obs_q.pop_front(), e); end
      else void'(obs_q.pop_front());
    end
    n_cmp++; if (coins_paid !== 4'(exp_cp)) begin n_bad++; $display("FAIL rstmid_coins_paid got %0d want %0d", coins_paid, exp_cp); end
    obs_q.delete();
    @(negedge clk);
  endtask

  task automatic test_sweep();
    int bals[10] = '{40, 41, 45, 50, 55, 59, 60, 62, 20, 0};
    bit to, us; int dk, fk, hd; int e;
    foreach (bals[i]) begin
      predict(bals[i]);
      run_sale(bals[i], int'($urandom_range(0, 2)), 1'b0, to, dk, fk, hd, us);
      n_cmp++; if (to) begin n_bad++; $display("FAIL sweep_timeout bal=%0d got no done want done", bals[i]); end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (obs_q.size() == 0) begin n_bad++; $display("FAIL sweep_coin bal=%0d got none want %0d", bals[i], e); end
        else if (obs_q[0] !== e) begin n_bad++; $display("FAIL sweep_coin bal=%0d got %0d want %0d", bals[i], obs_q.pop_front(), e); end
        else void'(obs_q.pop_front());
      end
      n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL sweep_extra bal=%0d got %0d want 0", bals[i], obs_q.size()); obs_q.delete(); end
      n_cmp++; if ({underpay, short, coins_paid} !== {exp_up, exp_sh, 4'(exp_cp)}) begin
        n_bad++; $display("FAIL sweep_status bal=%0d got up=%b sh=%b paid=%0d want up=%b sh=%b paid=%0d",
                          bals[i], underpay, short, coins_paid, exp_up, exp_sh, exp_cp);
      end
      @(negedge clk);
    end
  endtask

`ifdef CHANGE_INVENTORY_EN
  task automatic test_inventory();
    int bals[4] = '{60, 60, 50, 45};
    bit to, us; int dk, fk, hd; int e;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    obs_q.delete();
    foreach (bals[i]) begin
      predict(bals[i]);
      run_sale(bals[i], 0, 1'b0, to, dk, fk, hd, us);
      n_cmp++; if (to) begin n_bad++; $display("FAIL inv_timeout bal=%0d got no done want done", bals[i]); end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (obs_q.size() == 0) begin n_bad++; $display("FAIL inv_coin bal=%0d got none want %0d", bals[i], e); end
        else if (obs_q[0] !== e) begin n_bad++; $display("FAIL inv_coin bal=%0d got %0d want %0d", bals[i], obs_q.pop_front(), e); end
        else void'(obs_q.pop_front());
      end
      n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL inv_extra bal=%0d got %0d want 0", bals[i], obs_q.size()); obs_q.delete(); end
      n_cmp++; if ({short, coins_paid} !== {exp_sh, 4'(exp_cp)}) begin
        n_bad++; $display("FAIL inv_status bal=%0d got sh=%b paid=%0d want sh=%b paid=%0d", bals[i], short, coins_paid, exp_sh, exp_cp);
      end
      n_cmp++; if (stock_empty !== (m20 == 0 && m10 == 0 && m5 == 0)) begin
        n_bad++; $display("FAIL inv_stock_empty bal=%0d got %b want %b", bals[i], stock_empty, (m20 == 0 && m10 == 0 && m5 == 0));
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    clk = 1'b0;
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_exact();
    test_short();
    test_underpay();
    test_slow_ack();
    test_reset_mid();
    test_sweep();
`ifdef CHANGE_INVENTORY_EN
    test_inventory();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
